nco_slot_sched: RTL and testbench
=================================

Name: nco_slot_sched

Overview:
- Slot scheduler and sync-request controller for the time-multiplexed NCO phase-accumulator datapath.
- Steps the (voice, oscillator) slot indices that address the NCO state RAM, one slot per clock.
- Accepts note-on phase-reset requests from the key assigner, holds them per voice, and asserts the accumulator-zero flag during the owning voice's slots in the next full frame.
- Sits between the key assigner / pitch logic and the NCO bank.

Parameters:
- VOICES, 32, number of voices; power of two.
- V_OSC, 8, oscillators per voice; power of two.
- V_WIDTH, 5, voice index width, equal to log2(VOICES).
- O_WIDTH, 3, oscillator index width, equal to log2(V_OSC).

Ports:
- sCLK_XVXENVS  in  1  slot clock; all logic on its rising edge.
- reset_reg_N  in  1  asynchronous active-low reset.
- run  in  1  slot stepping enable.
- sync_mask  in  V_OSC  bit o=1: oscillator o is phase-reset on note-on; sampled when a voice is armed.
- req_valid  in  1  note-on reset request valid.
- req_vx  in  V_WIDTH  voice index of the request.
- req_ready  out  1  request accepted when req_valid & req_ready.
- vx  out  V_WIDTH  current voice slot index.
- ox  out  O_WIDTH  current oscillator slot index.
- slot_valid  out  1  vx/ox denote a live slot this cycle.
- frame_start  out  1  high in slot (0,0) when slot_valid.
- osc_accum_zero  out  1  zero the accumulator for slot (vx,ox); aligned with vx/ox.
- pend_any  out  1  OR of all pending and armed bits.

Behaviour:
- Reset (async, reset_reg_N=0): vx=0, ox=0, slot_valid=0, frame_start=0, osc_accum_zero=0, req_ready=0, pend_any=0; all pending[], armed[] and mask regs cleared.
- Slot counter:
  - When run=1: ox increments each clock. On ox==V_OSC-1, ox wraps to 0 and vx increments. On vx==VOICES-1 with ox==V_OSC-1, both wrap to 0.
  - slot_valid is registered run, delayed one clock so it aligns with the index regs.
  - When run=0: counters hold and slot_valid=0 next clock. Deasserting run mid-frame does not reset the counters; stepping resumes where it stopped.
- frame_start = slot_valid & vx==0 & ox==0.
- req_ready = registered run; it is 0 for the first clock after reset release.
- Request accept:
  - On req_valid & req_ready, pending[req_vx] is set next clock.
  - A duplicate request to an already-pending voice has no further effect.
- Arming:
  - In the clock where the counter enters slot (v,0) with run=1: armed[v] <= pending[v], sampled from the registered value; mask_reg[v] <= sync_mask; pending[v] cleared if it was set.
  - Simultaneous accept of a request for v in that same clock: pending[v] ends set; the voice is armed at the following frame, not the current one.
  - Accept for v while armed[v]=1: pending[v] set; this gives a second reset in the next frame.
- Output:
  - osc_accum_zero = slot_valid & armed[vx] & mask_reg[vx][ox], registered together with vx/ox so all three are coincident.
  - armed[v] is cleared after slot (v,V_OSC-1) is emitted.
- Latency: a request accepted at clock t yields its first osc_accum_zero no earlier than the next (v,0) slot after t+1, and no later than t+1+VOICES*V_OSC+1 clocks.
- Boundaries:
  - run=0 while armed: armed state is held and resumes with the slots.
  - Reset mid-frame drops all pending requests.
  - mask_reg=0 arms the voice but produces no zero pulses.
- pend_any is registered.

Test Plan:
1. Reset release, run=1, VOICES=32, V_OSC=8 -> vx/ox step 0..7 per voice; frame_start every 256 clocks; slot_valid high from the 2nd clock.
2. Accept req_vx=3 while counter at (10,2), sync_mask=8'b0000_0101 -> osc_accum_zero high only at slots (3,0) and (3,2) of the next frame; pending and armed clear afterwards; pend_any falls after (3,7).
3. Accept req_vx=5 in the exact clock the counter enters (5,0) -> no zero pulses this frame; pulses on (5,*) masked slots in the following frame.
4. Accept req_vx=7 twice while armed[7] is high at (7,3) -> masked zeros in the remainder of this frame's voice-7 slots and again in the next frame; no third frame.
5. Drop run=0 at (12,4) for 20 clocks with voice 12 armed -> slot_valid=0 and osc_accum_zero=0 during the stall; resumes at (12,5) with the remaining masked zeros intact.
6. Assert reset_reg_N=0 mid-frame with three voices pending -> outputs zero immediately; after release, no zero pulses in the next two frames.

Source files
------------

// File: rtl/nco_slot_sched.sv
// Slot scheduler for the time-multiplexed NCO bank: steps (voice, osc) slots one per clock
// and turns note-on requests into accumulator-zero strobes on the owning voice's next frame.
module nco_slot_sched #(
    parameter int VOICES  = 32,
    parameter int V_OSC   = 8,
    parameter int V_WIDTH = 5,
    parameter int O_WIDTH = 3
) (
    input  logic               sCLK_XVXENVS,
    input  logic               reset_reg_N,
    input  logic               run,
    input  logic [V_OSC-1:0]   sync_mask,
    input  logic               req_valid,
    input  logic [V_WIDTH-1:0] req_vx,
    output logic               req_ready,
    output logic [V_WIDTH-1:0] vx,
    output logic [O_WIDTH-1:0] ox,
    output logic               slot_valid,
    output logic               frame_start,
    output logic               osc_accum_zero,
    output logic               pend_any
);
    localparam int                 SW      = V_WIDTH + O_WIDTH;
    localparam logic [O_WIDTH-1:0] OX_LAST = O_WIDTH'(V_OSC - 1);

    logic [SW-1:0]      slot_p0;
    logic [V_WIDTH-1:0] vx_p0;
    logic [O_WIDTH-1:0] ox_p0;
    logic [VOICES-1:0]  pending;
    logic [VOICES-1:0]  armed;
    logic [VOICES-1:0]  pending_nxt;
    logic [VOICES-1:0]  armed_nxt;
    logic [V_OSC-1:0]   mask_reg [VOICES];
    logic               zero_p0;
    logic               accept;

    assign {vx_p0, ox_p0} = slot_p0;
    assign accept         = req_valid & req_ready;

    // Stage p0: slot about to be emitted. Entering (v,0) moves pending into armed and
    // uses the live sync_mask for bit 0, since mask_reg is loaded on this same edge.
    always_comb begin
        pending_nxt = pending;
        armed_nxt   = armed;
        zero_p0     = 1'b0;
        if (run) begin
            if (ox_p0 == '0) begin
                armed_nxt[vx_p0]   = pending[vx_p0];
                pending_nxt[vx_p0] = 1'b0;
                zero_p0            = pending[vx_p0] & sync_mask[ox_p0];
            end else begin
                zero_p0 = armed[vx_p0] & mask_reg[vx_p0][ox_p0];
                if (ox_p0 == OX_LAST) begin
                    armed_nxt[vx_p0] = 1'b0;
                end
            end
        end
        // Accept wins over the arming clear so a request landing on (v,0) waits a frame.
        if (accept) begin
            pending_nxt[req_vx] = 1'b1;
        end
    end

    // Stage p1: emitted slot, its zero strobe and status, all coincident.
    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            slot_p0        <= '0;
            vx             <= '0;
            ox             <= '0;
            slot_valid     <= 1'b0;
            req_ready      <= 1'b0;
            osc_accum_zero <= 1'b0;
            pend_any       <= 1'b0;
            pending        <= '0;
            armed          <= '0;
            for (int v = 0; v < VOICES; v++) begin
                mask_reg[v] <= '0;
            end
        end else begin
            slot_valid     <= run;
            req_ready      <= run;
            osc_accum_zero <= zero_p0;
            pending        <= pending_nxt;
            armed          <= armed_nxt;
            pend_any       <= |(pending | armed);
            if (run) begin
                vx      <= vx_p0;
                ox      <= ox_p0;
                slot_p0 <= slot_p0 + SW'(1);
                if (ox_p0 == '0) begin
                    mask_reg[vx_p0] <= sync_mask;
                end
            end
        end
    end

    assign frame_start = slot_valid & (vx == '0) & (ox == '0);

endmodule

// File: tb/tb_nco_slot_sched.sv
// Bench for nco_slot_sched: directed scenarios plus random traffic, checked against a
// slot-stream model that schedules each request onto the first later (v,0) emission.
module tb_nco_slot_sched;
    localparam int VOICES = 32;
    localparam int V_OSC  = 8;
    localparam int SLOTS  = VOICES * V_OSC;

    logic       clk;
    logic       reset_reg_N;
    logic       run;
    logic [7:0] sync_mask;
    logic       req_valid;
    logic [4:0] req_vx;
    logic       req_ready;
    logic [4:0] vx;
    logic [2:0] ox;
    logic       slot_valid;
    logic       frame_start;
    logic       osc_accum_zero;
    logic       pend_any;

    int vecs = 0;
    int errs = 0;

    nco_slot_sched #(.VOICES(VOICES), .V_OSC(V_OSC), .V_WIDTH(5), .O_WIDTH(3)) dut (
        .sCLK_XVXENVS  (clk),
        .reset_reg_N   (reset_reg_N),
        .run           (run),
        .sync_mask     (sync_mask),
        .req_valid     (req_valid),
        .req_vx        (req_vx),
        .req_ready     (req_ready),
        .vx            (vx),
        .ox            (ox),
        .slot_valid    (slot_valid),
        .frame_start   (frame_start),
        .osc_accum_zero(osc_accum_zero),
        .pend_any      (pend_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: E counts slots emitted since reset; fire holds stream indices of (v,0)
    // emissions that start an armed voice; mask_at holds sync_mask seen at each (v,0).
    longint     E;
    int         m_last;
    bit         m_sv, m_ready, m_zero, m_pa;
    bit         fire [longint];
    logic [7:0] mask_at [longint];

    function automatic void model_reset();
        E = 0; m_last = 0; m_sv = 0; m_ready = 0; m_zero = 0; m_pa = 0;
        fire.delete();
        mask_at.delete();
    endfunction

    function automatic void model_edge();
        longint i = E;
        int     o = int'(i % V_OSC);
        bit     pa = 1'b0;
        bit     z  = 1'b0;
        foreach (fire[b]) if (b + V_OSC - 1 >= E) pa = 1'b1;
        if (run) begin
            if (o == 0) mask_at[i] = sync_mask;
            z = fire.exists(i - o) && mask_at[i - o][o];
            m_last = int'(i % SLOTS);
            E++;
        end
        if (req_valid && m_ready) begin
            longint j = E;
            while (j % SLOTS != longint'(req_vx) * V_OSC) j++;
            fire[j] = 1'b1;
        end
        m_zero = z; m_sv = run; m_ready = run; m_pa = pa;
    endfunction

    function automatic logic [12:0] expv();
        return {5'(m_last / V_OSC), 3'(m_last % V_OSC), m_sv, m_sv && (m_last == 0),
                m_zero, m_pa, m_ready};
    endfunction

    function automatic logic [12:0] actv();
        return {vx, ox, slot_valid, frame_start, osc_accum_zero, pend_any, req_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_reg_N = 1'b0; run = 1'b0; req_valid = 1'b0; req_vx = '0; sync_mask = '0;
        model_reset();
        #1;
        vecs++;
        if (actv() !== expv()) begin errs++; $display("FAIL reset_state got %h exp %h", actv(), expv()); end
        @(negedge clk);
        reset_reg_N = 1'b1; run = 1'b1;
        #1;
        vecs++;
        if (req_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b exp 0", req_ready); end
        tick();
        vecs++;
        if (actv() !== expv()) begin errs++; $display("FAIL first_slot got %h exp %h", actv(), expv()); end
    endtask

    task automatic test_counting();
        int last_fs = 0;
        for (int k = 1; k <= 600; k++) begin
            tick(); vecs++;
            if (actv() !== expv()) begin errs++; $display("FAIL counting got %h exp %h", actv(), expv()); end
            if (frame_start) begin
                vecs++;
                if (k - last_fs != SLOTS) begin errs++; $display("FAIL frame_period got %0d exp %0d", k - last_fs, SLOTS); end
                last_fs = k;
            end
        end
    endtask

    task automatic test_single_req();
        int zc = 0;
        sync_mask = 8'b0000_0101;
        for (int k = 0; k < 600 && !(m_sv && m_last == 10 * V_OSC + 2); k++) begin
            tick(); vecs++;
            if (actv() !== expv()) begin errs++; $display("FAIL single_pos got %h exp %h", actv(), expv()); end
        end
        vecs++;
        if ({vx, ox} !== 8'd82) begin errs++; $display("FAIL single_at got %h exp 52", {vx, ox}); end
        req_valid = 1'b1; req_vx = 5'd3;
        tick(); vecs++;
        if (actv() !== expv()) begin errs++; $display("FAIL single_acc got %h exp %h", actv(), expv()); end
        req_valid = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick(); vecs++; zc += int'(osc_accum_zero);
            if (actv() !== expv()) begin errs++; $display("FAIL single_req got %h exp %h", actv(), expv()); end
            if (osc_accum_zero && !({vx, ox} == 8'd24 || {vx, ox} == 8'd26)) begin
                vecs++; errs++; $display("FAIL single_slot got %h exp 18 or 1a", {vx, ox});
            end
        end
        vecs++;
        if (zc != 2 || pend_any !== 1'b0) begin errs++; $display("FAIL single_count got %0d/%b exp 2/0", zc, pend_any); end
    endtask

    task automatic test_enter_edge();
        int zc1 = 0, zc2 = 0;
        for (int k = 0; k < 600 && !(m_sv && m_last == 4 * V_OSC + 7); k++) begin
            tick(); vecs++;
            if (actv() !== expv()) begin errs++; $display("FAIL edge_pos got %h exp %h", actv(), expv()); end
        end
        vecs++;
        if ({vx, ox} !== 8'd39) begin errs++; $display("FAIL edge_at got %h exp 27", {vx, ox}); end
        sync_mask = 8'b1100_0001; req_valid = 1'b1; req_vx = 5'd5;
        tick(); vecs++;
        if (actv() !== expv()) begin errs++; $display("FAIL edge_acc got %h exp %h", actv(), expv()); end
        req_valid = 1'b0;
        for (int k = 0; k < 255 + 12; k++) begin
            tick(); vecs++;
            if (k < 255) zc1 += int'(osc_accum_zero); else zc2 += int'(osc_accum_zero);
            if (actv() !== expv()) begin errs++; $display("FAIL enter_edge got %h exp %h", actv(), expv()); end
        end
        vecs++;
        if (zc1 != 0 || zc2 != 3) begin errs++; $display("FAIL edge_count got %0d/%0d exp 0/3", zc1, zc2); end
    endtask

    task automatic test_rearm();
        int zc = 0;
        sync_mask = 8'b1010_1011;
        for (int k = 0; k < 600 && !(m_sv && m_last == 6 * V_OSC); k++) begin
            tick(); vecs++;
            if (actv() !== expv()) begin errs++; $display("FAIL rearm_pos got %h exp %h", actv(), expv()); end
        end
        req_valid = 1'b1; req_vx = 5'd7;
        tick(); vecs++; zc += int'(osc_accum_zero);
        if (actv() !== expv()) begin errs++; $display("FAIL rearm_acc got %h exp %h", actv(), expv()); end
        req_valid = 1'b0;
        for (int k = 0; k < 600 && !(m_sv && m_last == 7 * V_OSC + 3); k++) begin
            tick(); vecs++; zc += int'(osc_accum_zero);
            if (actv() !== expv()) begin errs++; $display("FAIL rearm_wait got %h exp %h", actv(), expv()); end
        end
        vecs++;
        if ({vx, ox} !== 8'd59) begin errs++; $display("FAIL rearm_at got %h exp 3b", {vx, ox}); end
        req_valid = 1'b1;
        for (int k = 0; k < 2 + 3 * SLOTS; k++) begin
            tick(); vecs++; zc += int'(osc_accum_zero);
            if (actv() !== expv()) begin errs++; $display("FAIL rearm got %h exp %h", actv(), expv()); end
            req_valid = 1'b0;
        end
        vecs++;
        if (zc != 10) begin errs++; $display("FAIL rearm_count got %0d exp 10", zc); end
    endtask

    task automatic test_stall();
        int zc_pre = 0, zc_stall = 0, zc_post = 0;
        sync_mask = 8'b1011_0110;
        for (int k = 0; k < 600 && !(m_sv && m_last == 11 * V_OSC); k++) begin
            tick(); vecs++;
            if (actv() !== expv()) begin errs++; $display("FAIL stall_pos got %h exp %h", actv(), expv()); end
        end
        req_valid = 1'b1; req_vx = 5'd12;
        for (int k = 0; k < 600 && !(m_sv && m_last == 12 * V_OSC + 4); k++) begin
            tick(); vecs++; zc_pre += int'(osc_accum_zero); req_valid = 1'b0;
            if (actv() !== expv()) begin errs++; $display("FAIL stall_wait got %h exp %h", actv(), expv()); end
        end
        vecs++;
        if ({vx, ox} !== 8'd100) begin errs++; $display("FAIL stall_at got %h exp 64", {vx, ox}); end
        run = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(); vecs++; zc_stall += int'(osc_accum_zero);
            if (actv() !== expv()) begin errs++; $display("FAIL stall got %h exp %h", actv(), expv()); end
        end
        run = 1'b1;
        tick(); vecs++;
        if ({vx, ox, slot_valid} !== {8'd101, 1'b1}) begin errs++; $display("FAIL stall_resume got %h exp 65", {vx, ox}); end
        zc_post += int'(osc_accum_zero);
        for (int k = 0; k < 10; k++) begin
            tick(); vecs++; zc_post += int'(osc_accum_zero);
            if (actv() !== expv()) begin errs++; $display("FAIL stall_post got %h exp %h", actv(), expv()); end
        end
        vecs++;
        if (zc_pre != 3 || zc_stall != 0 || zc_post != 2) begin
            errs++; $display("FAIL stall_count got %0d/%0d/%0d exp 3/0/2", zc_pre, zc_stall, zc_post);
        end
    endtask

    task automatic test_reset_mid();
        int zc = 0;
        sync_mask = 8'hFF;
        for (int k = 0; k < 600 && !(m_sv && m_last == 15 * V_OSC); k++) begin
            tick(); vecs++;
            if (actv() !== expv()) begin errs++; $display("FAIL rmid_pos got %h exp %h", actv(), expv()); end
        end
        for (int k = 0; k < 6; k++) begin
            req_valid = (k < 3); req_vx = 5'(20 + k);
            tick(); vecs++;
            if (actv() !== expv()) begin errs++; $display("FAIL rmid_req got %h exp %h", actv(), expv()); end
        end
        req_valid = 1'b0;
        #2 reset_reg_N = 1'b0;
        model_reset();
        #1 vecs++;
        if (actv() !== 13'd0) begin errs++; $display("FAIL rmid_zero got %h exp 0", actv()); end
        @(negedge clk);
        reset_reg_N = 1'b1;
        for (int k = 0; k < 2 * SLOTS + 4; k++) begin
            tick(); vecs++; zc += int'(osc_accum_zero);
            if (actv() !== expv()) begin errs++; $display("FAIL reset_mid got %h exp %h", actv(), expv()); end
        end
        vecs++;
        if (zc != 0) begin errs++; $display("FAIL rmid_count got %0d exp 0", zc); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            run       = ($urandom_range(0, 9) != 0);
            req_valid = ($urandom_range(0, 3) == 0);
            req_vx    = 5'($urandom_range(0, VOICES - 1));
            sync_mask = 8'($urandom);
            tick(); vecs++;
            if (actv() !== expv()) begin errs++; $display("FAIL random got %h exp %h", actv(), expv()); end
        end
        run = 1'b1; req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_counting();
        test_single_req();
        test_enter_edge();
        test_rearm();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
